// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states
// and datapath mux selects. Used by the controller and the datapath.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts unanswered memory-request cycles and flags expiry on the last allowed
// cycle; TIMEOUT of 0 disables the check.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT > 0) && count && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one shared req/ready memory port.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_br_taken,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_sel_d,
  output logic        o_ir_we,
  output logic [6:0]  o_opcode,
  output logic        o_signext,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_src,
  output logic [1:0]  o_alu_a_src,
  output logic        o_alu_b_src,
  output logic        o_reg_we,
  output logic [1:0]  o_wb_src,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [2:0]  o_state
);
  import rv_ctrl_pkg::*;

  state_t     state, state_nx;
  logic [6:0] opcode;
  logic       illegal, bus_err;
  logic       expired, wait_clear, wait_count;
  logic       instr_unused;

  // Only the opcode field is held here; the datapath's IR keeps the rest.
  assign instr_unused = ^i_instr[31:7];

  logic is_load, is_store, is_jal, is_jalr, is_branch, is_lui, is_auipc, is_op;
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_op     = (opcode == OPC_OP);

  // Counter is held at zero outside the two memory states, so it starts fresh on entry.
  assign wait_clear = i_mem_ready || !((state == ST_FETCH) || (state == ST_MEM));
  assign wait_count = o_mem_req && !i_mem_ready;

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (wait_clear),
    .count   (wait_count),
    .expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_FETCH;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opcode  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && i_mem_ready)            opcode  <= i_instr[6:0];
      if ((state == ST_DECODE) && !opcode_legal(opcode)) illegal <= 1'b1;
      if (expired)                                       bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH: begin
        if (i_mem_ready)  state_nx = ST_DECODE;
        else if (expired) state_nx = ST_TRAP;
      end
      ST_DECODE: state_nx = opcode_legal(opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (is_branch || is_jal || is_jalr) state_nx = ST_FETCH;
        else if (is_load || is_store)       state_nx = ST_MEM;
        else                                state_nx = ST_WB;
      end
      ST_MEM: begin
        if (i_mem_ready)  state_nx = is_load ? ST_WB : ST_FETCH;
        else if (expired) state_nx = ST_TRAP;
      end
      ST_WB:   state_nx = ST_FETCH;
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_FETCH;
    endcase
  end

  // Enables are forced low while reset is asserted so an aborted access never commits.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_sel_d = 1'b0;
    o_ir_we     = 1'b0;
    o_signext   = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_src    = PC_PLUS4;
    o_alu_a_src = A_RS1;
    o_alu_b_src = B_RS2;
    o_reg_we    = 1'b0;
    o_wb_src    = WB_ALU;
    if (i_rst_n) begin
      case (state)
        ST_FETCH: begin
          o_mem_req = 1'b1;
          o_ir_we   = i_mem_ready;
        end
        ST_DECODE: o_signext = 1'b1;
        ST_EXEC: begin
          o_signext   = 1'b1;
          o_alu_a_src = (is_auipc || is_jal) ? A_PC : (is_lui ? A_ZERO : A_RS1);
          o_alu_b_src = (is_op || is_branch) ? B_RS2 : B_IMM;
          if (is_branch) begin
            o_pc_we  = 1'b1;
            o_pc_src = i_br_taken ? PC_IMM : PC_PLUS4;
          end else if (is_jal || is_jalr) begin
            o_pc_we  = 1'b1;
            o_pc_src = is_jal ? PC_IMM : PC_ALU;
            o_reg_we = 1'b1;
            o_wb_src = WB_PC4;
          end
        end
        ST_MEM: begin
          o_signext   = 1'b1;
          o_mem_req   = 1'b1;
          o_mem_sel_d = 1'b1;
          o_mem_we    = is_store;
          if (i_mem_ready && is_store) o_pc_we = 1'b1;
        end
        ST_WB: begin
          o_signext = 1'b1;
          o_reg_we  = 1'b1;
          o_wb_src  = is_load ? WB_MEM : WB_ALU;
          o_pc_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_opcode  = opcode;
  assign o_illegal = illegal;
  assign o_bus_err = bus_err;
  assign o_state   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions plus randomized traffic,
// checked cycle by cycle against an instruction-level expectation model.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_mem_ready, i_br_taken;
  logic [31:0] i_instr;
  logic        o_mem_req, o_mem_we, o_mem_sel_d, o_ir_we, o_signext, o_pc_we;
  logic        o_alu_b_src, o_reg_we, o_illegal, o_bus_err;
  logic [6:0]  o_opcode;
  logic [1:0]  o_pc_src, o_alu_a_src, o_wb_src;
  logic [2:0]  o_state;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_mem_ready(i_mem_ready),
    .i_br_taken(i_br_taken), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_sel_d(o_mem_sel_d), .o_ir_we(o_ir_we), .o_opcode(o_opcode),
    .o_signext(o_signext), .o_pc_we(o_pc_we), .o_pc_src(o_pc_src),
    .o_alu_a_src(o_alu_a_src), .o_alu_b_src(o_alu_b_src), .o_reg_we(o_reg_we),
    .o_wb_src(o_wb_src), .o_illegal(o_illegal), .o_bus_err(o_bus_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, sel, irwe;
    logic [6:0] op;
    logic       sx, pcwe;
    logic [1:0] pcs, as;
    logic       bs, rwe;
    logic [1:0] wbs;
    logic       ill, be;
  } sig_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [6:0]  cur_op;
  logic        cur_ill, cur_be, rel_pending, tr;
  logic [6:0]  legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011};

  function automatic logic legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic sig_t base(input logic [2:0] st);
    sig_t e;
    e     = '0;
    e.st  = st;
    e.op  = cur_op;
    e.ill = cur_ill;
    e.be  = cur_be;
    e.sx  = (st >= 3'd1) && (st <= 3'd4);
    return e;
  endfunction

  task automatic cmp(input string tag, input sig_t e);
    sig_t obs;
    obs = {o_state, o_mem_req, o_mem_we, o_mem_sel_d, o_ir_we, o_opcode, o_signext,
           o_pc_we, o_pc_src, o_alu_a_src, o_alu_b_src, o_reg_we, o_wb_src,
           o_illegal, o_bus_err};
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic br,
                     input logic [31:0] ins, input sig_t e);
    @(negedge i_clk);
    if (rel_pending) begin
      i_rst_n     = 1'b1;
      rel_pending = 1'b0;
    end
    i_mem_ready = rdy;
    i_br_taken  = br;
    i_instr     = ins;
    #1;
    cmp(tag, e);
  endtask

  // Called just after i_rst_n has been pulled low; release happens on the next driven cycle.
  task automatic enter_reset(input string tag);
    #1;
    cmp(tag, '0);
    @(negedge i_clk);
    #1;
    cmp({tag, "_hold"}, '0);
    cur_op      = '0;
    cur_ill     = 1'b0;
    cur_be      = 1'b0;
    rel_pending = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    i_rst_n     = 1'b0;
    enter_reset("reset");
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) cyc("trap", rb(), rb(), $urandom, base(3'd5));
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic br, input int abort_mem, output logic trapped);
    sig_t       e;
    logic [6:0] op;
    op      = ins[6:0];
    trapped = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      e     = base(3'd0);
      e.req = 1'b1;
      if (i == fw) begin
        e.irwe = 1'b1;
        cyc("fetch_done", 1'b1, rb(), ins, e);
      end else begin
        cyc("fetch_wait", 1'b0, rb(), $urandom, e);
        if (i == TO - 1) begin cur_be = 1'b1; trapped = 1'b1; return; end
      end
    end
    cur_op = op;
    cyc("decode", rb(), rb(), $urandom, base(3'd1));
    if (!legal(op)) begin cur_ill = 1'b1; trapped = 1'b1; return; end
    e = base(3'd2);
    e.as = (op == 7'b0010111 || op == 7'b1101111) ? 2'b01 : (op == 7'b0110111) ? 2'b10 : 2'b00;
    e.bs = !(op == 7'b0110011 || op == 7'b1100011);
    if (op == 7'b1100011) begin
      e.pcwe = 1'b1; e.pcs = br ? 2'b01 : 2'b00;
    end else if (op == 7'b1101111 || op == 7'b1100111) begin
      e.pcwe = 1'b1; e.pcs = (op == 7'b1101111) ? 2'b01 : 2'b10;
      e.rwe  = 1'b1; e.wbs = 2'b10;
    end
    cyc("exec", rb(), br, $urandom, e);
    if (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111) return;
    if (op == 7'b0000011 || op == 7'b0100011) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_mem) begin
          @(negedge i_clk);
          i_mem_ready = 1'b0;
          #2 i_rst_n = 1'b0;
          enter_reset("abort");
          return;
        end
        e     = base(3'd3);
        e.req = 1'b1;
        e.sel = 1'b1;
        e.we  = (op == 7'b0100011);
        if (i == mw) begin
          e.pcwe = (op == 7'b0100011);
          cyc("mem_done", 1'b1, rb(), $urandom, e);
        end else begin
          cyc("mem_wait", 1'b0, rb(), $urandom, e);
          if (i == TO - 1) begin cur_be = 1'b1; trapped = 1'b1; return; end
        end
      end
      if (op == 7'b0100011) return;
    end
    e      = base(3'd4);
    e.rwe  = 1'b1;
    e.wbs  = (op == 7'b0000011) ? 2'b01 : 2'b00;
    e.pcwe = 1'b1;
    cyc("wb", rb(), rb(), $urandom, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_mem_ready = 1'b0; i_br_taken = 1'b0; i_instr = '0;
    cur_op = '0; cur_ill = 1'b0; cur_be = 1'b0; rel_pending = 1'b0;
    enter_reset("reset");

    run_instr(32'h00500093, 0, 0, 1'b0, -1, tr);   // ADDI
    run_instr(32'h0000A103, 0, 3, 1'b0, -1, tr);   // LW, 3 wait states
    run_instr(32'h00208463, 1, 0, 1'b1, -1, tr);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0, -1, tr);   // BEQ not taken
    run_instr(32'h008000EF, 0, 0, 1'b0, -1, tr);   // JAL
    run_instr(32'h000080E7, 2, 0, 1'b1, -1, tr);   // JALR
    run_instr(32'h0020A023, 0, 1, 1'b0, -1, tr);   // SW
    run_instr(32'h123450B7, 0, 0, 1'b0, -1, tr);   // LUI
    run_instr(32'h00001097, 0, 0, 1'b0, -1, tr);   // AUIPC
    run_instr(32'h002081B3, 0, 0, 1'b1, -1, tr);   // ADD

    run_instr(32'h0000007F, 0, 0, 1'b0, -1, tr);   // illegal opcode
    trap_hold(20);
    do_reset();

    run_instr(32'h00500093, 16, 0, 1'b0, -1, tr);  // fetch timeout
    trap_hold(3);
    do_reset();
    run_instr(32'h00500093, 15, 0, 1'b0, -1, tr);  // ready on the last allowed cycle
    run_instr(32'h0000A103, 0, 16, 1'b0, -1, tr);  // memory-stage timeout
    trap_hold(3);
    do_reset();
    run_instr(32'h0020A023, 0, 15, 1'b0, -1, tr);  // store completes on last allowed cycle

    run_instr(32'h0020A023, 0, 3, 1'b0, 2, tr);    // SW aborted by reset mid-MEM
    run_instr(32'h00500093, 0, 0, 1'b0, -1, tr);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ins;
      int          fw, mw;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = legal_ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      run_instr(ins, fw, mw, rb(), -1, tr);
      if (tr) begin
        trap_hold(int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over one shared memory port with a req/ready handshake.
- Holds the latched opcode and drives the immediate decoder's opcode and sign-extend inputs.
- Drives every datapath mux/write-enable, and flags illegal opcodes and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles o_mem_req may stay high without i_mem_ready before bus error; 0 disables timeout
CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_instr  in  32  memory read data; captured as instruction in FETCH
i_mem_ready  in  1  memory completes current access this cycle
i_br_taken  in  1  branch compare result from ALU, valid in EXEC
o_mem_req  out  1  memory access request
o_mem_we  out  1  store strobe (only with o_mem_req)
o_mem_sel_d  out  1  address select: 0 = PC, 1 = ALU result
o_ir_we  out  1  instruction register load enable
o_opcode  out  7  latched IR[6:0], to immediate decoder
o_signext  out  1  to immediate decoder
o_pc_we  out  1  PC load enable
o_pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
o_alu_a_src  out  2  00 rs1, 01 PC, 10 zero
o_alu_b_src  out  1  0 rs2, 1 imm
o_reg_we  out  1  register file write enable
o_wb_src  out  2  00 ALU, 01 memory data, 10 PC+4
o_illegal  out  1  sticky illegal-opcode flag
o_bus_err  out  1  sticky timeout flag
o_state  out  3  current state, debug

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=FETCH, opcode reg=0, counter=0, flags=0. All outputs 0 while reset is low.
- Reset may assert in any state and aborts the access in progress; no write enable fires. After release, the first cycle is FETCH with o_mem_req=1.
- Outputs are decoded from the state register plus the latched opcode only. i_br_taken and i_mem_ready additionally gate enables in the same cycle.
- States (o_state encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: o_mem_req=1, o_mem_sel_d=0. When i_mem_ready=1: o_ir_we=1, opcode reg <= i_instr[6:0], next DECODE. Otherwise stay.
- DECODE: 1 cycle.
  - o_signext=1 from DECODE onward, 0 in FETCH and TRAP.
  - Legal opcodes: 0000011, 0100011, 1101111, 1100111, 1100011, 0110111, 0010111, 0010011, 0110011.
  - Any other opcode: o_illegal<=1, next TRAP. Legal: next EXEC.
- EXEC operand selects:
  - a_src: 01 for AUIPC/JAL; 10 for LUI; else 00.
  - b_src: 1 for all except OP (0110011) and Branch.
- EXEC by opcode:
  - Branch: o_pc_we=1; o_pc_src=01 if i_br_taken else 00; next FETCH.
  - JAL: o_pc_we=1, pc_src=01, o_reg_we=1, wb_src=10; next FETCH.
  - JALR: o_pc_we=1, pc_src=10, o_reg_we=1, wb_src=10; next FETCH. The ALU result is computed from the old rs1 before the write lands, so rd==rs1 is safe.
  - Load/Store: next MEM.
  - OP, OP-IMM, LUI, AUIPC: next WB.
- MEM: o_mem_req=1, o_mem_sel_d=1, o_mem_we=1 for Store. On i_mem_ready:
  - Load: next WB.
  - Store: o_pc_we=1, pc_src=00; next FETCH.
- WB: o_reg_we=1, wb_src=01 for Load else 00; o_pc_we=1, pc_src=00; next FETCH.
- TRAP: all enables 0, o_mem_req=0. Only reset exits TRAP.
- Wait counter:
  - Clears on entry to FETCH/MEM and on any cycle with i_mem_ready=1.
  - Increments each cycle with o_mem_req=1 and i_mem_ready=0.
  - If TIMEOUT>0 and counter==TIMEOUT-1 with ready still low: o_bus_err<=1, next TRAP.
  - i_mem_ready=1 on that same cycle wins: normal completion, no error.
- Exactly one o_pc_we pulse per retired instruction. Cycles per instruction: Branch/JAL/JALR 3, ALU 4, Store 4, Load 5, each plus memory wait states.
- Writes to x0 are filtered by the register file, not here.

Decomposition:
- Package rv_ctrl_pkg: opcode localparams, state encoding, and pc_src/alu_a_src/wb_src encodings; shared with datapath and bench.
- Sub-module ctrl_wait_timer: counter plus timeout compare, ports clear/count/expired, parameters TIMEOUT and CNT_W.

Test Plan:
- Reset, then ADDI (0x00500093) with ready=1 always -> states 0,1,2,4,0; reg_we=1 with wb_src=00 in WB; one pc_we with pc_src=00; b_src=1 and signext=1 in EXEC.
- LW (0x0000A103), 3 wait cycles in MEM -> o_mem_req held 4 cycles with sel_d=1, we=0; then WB with wb_src=01; 5+3 cycles total.
- BEQ (opcode 1100011), i_br_taken=1 -> pc_we with pc_src=01 in EXEC, no reg_we, back to FETCH. Repeat with i_br_taken=0 -> pc_src=00.
- i_instr=0x0000007F -> o_illegal=1 after DECODE; TRAP held 20 cycles with no req/we; deassert/assert i_rst_n -> FETCH, flags cleared.
- TIMEOUT=16, ready held 0 in FETCH -> o_bus_err=1 after 16 req cycles, then TRAP. Ready=1 on the 16th cycle -> normal DECODE, no error.
- SW (opcode 0100011), i_rst_n pulled low mid-MEM -> outputs 0 immediately with no pc_we; after release, FETCH with req=1.
